alu_exec_unit: RTL and testbench
================================

# alu_exec_unit

Registered execution unit that consumes the 3-bit `alu_control` code produced by the ALU decoder, together with two operands, and returns result and flags over a valid/ready handshake. It holds results in a 2-entry output FIFO, so the datapath can absorb one cycle of downstream stall without losing throughput. It sits between decode/operand-fetch and writeback in the upcoming handshaked core variant. It also keeps a wrapping count of retired operations for bring-up visibility.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥ 2)
- `CNT_W`, 16, width of retired-operation counter
- `clk`  in  1  rising-edge clock, single clock domain
- `rst_n`  in  1  synchronous active-low reset
- `in_valid`  in  1  operation presented
- `in_ready`  out  1  unit can accept an operation this cycle
- `alu_control`  in  3  operation code from ALU decoder
- `src_a`  in  WIDTH  operand A
- `src_b`  in  WIDTH  operand B
- `out_valid`  out  1  head result available
- `out_ready`  in  1  consumer takes head result this cycle
- `result`  out  WIDTH  head result
- `zero`  out  1  head result == 0
- `illegal`  out  1  head entry came from an unsupported code
- `op_count`  out  CNT_W  number of results popped, wraps modulo 2^CNT_W

## Operation
- Op codes:
  - 000: A+B
  - 001: A−B
  - 010: A&B
  - 011: A|B
  - 101: signed A<B, giving 1 or 0, zero-extended to WIDTH
- Add and subtract wrap modulo 2^WIDTH; there is no carry or overflow output.
- Codes 100, 110 and 111 are illegal. An illegal op is still accepted and produces an entry with result=0, zero=1, illegal=1.
- Accept: `in_valid && in_ready` at a rising edge. The result is computed combinationally from the inputs in that cycle and written into the FIFO tail at that edge.
- Pop: `out_valid && out_ready` at a rising edge removes the head and increments `op_count` by 1.
- FIFO state is occupancy `count` ∈ {0,1,2} plus head/tail pointers (or an equivalent shift structure). Entries are popped strictly in acceptance order.
- `in_ready` = (count < 2). It is a registered-state function only and does not depend on `out_ready`; there is no pass-through when full.
- `out_valid` = (count ≠ 0). When `out_valid`=0, `result`, `zero` and `illegal` are driven 0.
- Simultaneous push and pop at count=1: count stays 1, the new entry becomes head, and ordering is preserved.
- Simultaneous push and pop at count=0 is impossible because `out_valid`=0.
- Inputs are ignored whenever `in_valid`=0 or `in_ready`=0; operands need not be stable in those cycles.
- `op_count` wraps from 2^CNT_W−1 to 0 with no flag.

## Timing
- Reset (`rst_n`=0 at a rising edge): count=0, pointers=0, `op_count`=0. Consequently `in_ready`=1, `out_valid`=0, `result`=0, `zero`=0, `illegal`=0 after that edge.
- Reset mid-operation discards all stored entries; no pop is counted for them.
- Latency: an op accepted at edge N appears at the head with `out_valid`=1 after edge N if the FIFO was empty. Otherwise it appears after the edge that pops its predecessor.
- Throughput: 1 op/cycle while `out_ready`=1 continuously.
- With `out_ready`=0, two ops are accepted and `in_ready` falls after the second accept edge. It rises again after the first pop edge.
- Head outputs stay stable while `out_valid`=1 and `out_ready`=0.

## Test plan
- Basic ops:
  - Stimulus: WIDTH=32, `out_ready`=1; push (000, 5, 7), then (001, 3, 3), then (010, 0xF0F0, 0x0FF0), then (011, 0xF000, 0x000F).
  - Required response: results 12, 0 (with zero=1), 0x00F0, 0xF00F, each one cycle after its accept; `op_count`=4 at the end.
- SLT signedness:
  - Stimulus: (101, 0xFFFFFFE0, 1), then (101, 1, 0xFFFFFFE0).
  - Required response: results 1 and 0 respectively.
  - Stimulus: (000, 0xFFFFFFFF, 1).
  - Required response: result 0, zero=1.
- Illegal code:
  - Stimulus: push (100, 9, 9).
  - Required response: result 0, zero=1, illegal=1; `op_count` increments on its pop.
- Backpressure:
  - Stimulus: `out_ready`=0; offer ops A, B, C back-to-back.
  - Required response: A and B accepted, `in_ready`=0 with C held off, head=A stable.
  - Stimulus: raise `out_ready`.
  - Required response: pops A, B, C in order with C accepted the cycle after the first pop; no loss or duplication.
- Reset mid-operation:
  - Stimulus: fill 2 entries, assert `rst_n`=0 for one edge.
  - Required response: `out_valid`=0, `in_ready`=1, `op_count`=0 and all outputs 0 on the next cycle; the old entries never appear.
- Counter wrap:
  - Stimulus: CNT_W=4; pop 17 ops.
  - Required response: `op_count` reads 15 after the 15th pop, 0 after the 16th, 1 after the 17th.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Registered ALU execution stage with a 2-entry result FIFO and valid/ready
// handshakes on both sides; counts retired (popped) operations.
module alu_exec_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b101;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic             slt;

   logic [WIDTH-1:0] res_q [2];
   logic             ill_q [2];
   logic             head_q;
   logic             tail_q;
   logic [1:0]       count_q;
   logic [CNT_W-1:0] op_count_q;

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head_res;

   assign slt = $signed(src_a) < $signed(src_b);

   always_comb begin
      alu_res = '0;
      alu_ill = 1'b0;
      unique case (alu_control)
         OP_ADD:  alu_res = src_a + src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
         default: alu_ill = 1'b1;
      endcase
   end

   // Ready depends only on occupancy: no pass-through when full.
   assign in_ready  = (count_q != 2'd2);
   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (push) begin
         res_q[tail_q] <= alu_res;
         ill_q[tail_q] <= alu_ill;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q     <= 1'b0;
         tail_q     <= 1'b0;
         count_q    <= 2'd0;
         op_count_q <= '0;
      end else begin
         if (push) begin
            tail_q <= ~tail_q;
         end
         if (pop) begin
            head_q     <= ~head_q;
            op_count_q <= op_count_q + CNT_W'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_res = res_q[head_q];
   assign result   = out_valid ? head_res : '0;
   assign zero     = out_valid && (head_res == '0);
   assign illegal  = out_valid && ill_q[head_q];
   assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: table vectors, hand sequences for backpressure,
// reset and counter wrap, and random traffic against a queue model.
module tb_alu_exec_unit;

   localparam int W  = 32;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [2:0]    alu_control;
   logic [W-1:0]  src_a;
   logic [W-1:0]  src_b;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          zero;
   logic          illegal;
   logic [CW-1:0] op_count;

   alu_exec_unit #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .alu_control(alu_control),
      .src_a(src_a),
      .src_b(src_b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .result(result),
      .zero(zero),
      .illegal(illegal),
      .op_count(op_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] res;
      logic         z;
      logic         ill;
   } vec_t;

   typedef struct {
      logic [W-1:0] r;
      logic         ill;
   } ent_t;

   vec_t        vt [8];
   ent_t        mq [$];
   int unsigned mcnt;
   int          n_pass;
   int          n_tot;

   task automatic chk(input string n, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
   endtask

   function automatic ent_t ref_alu(input logic [2:0] op,
                                    input logic [W-1:0] a,
                                    input logic [W-1:0] b);
      ent_t e;
      e.r   = '0;
      e.ill = 1'b0;
      case (op)
         3'd0:    e.r = a + b;
         3'd1:    e.r = a - b;
         3'd2:    e.r = a & b;
         3'd3:    e.r = a | b;
         3'd5:    e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: e.ill = 1'b1;
      endcase
      return e;
   endfunction

   task automatic model_check();
      logic         v;
      logic [W-1:0] r;
      logic         il;
      v  = (mq.size() != 0);
      r  = v ? mq[0].r : '0;
      il = v ? mq[0].ill : 1'b0;
      chk("m_out_valid", 32'(out_valid), 32'(v));
      chk("m_in_ready", 32'(in_ready), 32'(mq.size() < 2));
      chk("m_result", result, r);
      chk("m_zero", 32'(zero), 32'(v && (r == '0)));
      chk("m_illegal", 32'(illegal), 32'(il));
      chk("m_op_count", 32'(op_count), mcnt);
   endtask

   // Drive one cycle of inputs, advance past the edge, update and check model.
   task automatic cyc(input logic rst, input logic iv, input logic [2:0] op,
                      input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic ordy);
      bit   do_push;
      bit   do_pop;
      ent_t e;
      rst_n       = rst;
      in_valid    = iv;
      alu_control = op;
      src_a       = a;
      src_b       = b;
      out_ready   = ordy;
      do_push = iv && (mq.size() < 2);
      do_pop  = ordy && (mq.size() > 0);
      e = ref_alu(op, a, b);
      @(posedge clk);
      #1;
      if (!rst) begin
         mq.delete();
         mcnt = 0;
      end else begin
         if (do_pop) begin
            void'(mq.pop_front());
            mcnt = (mcnt + 1) % (1 << CW);
         end
         if (do_push) mq.push_back(e);
      end
      model_check();
   endtask

   task automatic idle(input logic ordy);
      cyc(1'b1, 1'b0, 3'd0, '0, '0, ordy);
   endtask

   task automatic apply_vec(input int i);
      cyc(1'b1, 1'b1, vt[i].op, vt[i].a, vt[i].b, 1'b1);
      chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_result", i), result, vt[i].res);
      chk($sformatf("vec%0d_zero", i), 32'(zero), 32'(vt[i].z));
      chk($sformatf("vec%0d_illegal", i), 32'(illegal), 32'(vt[i].ill));
   endtask

   initial begin
      n_pass = 0;
      n_tot  = 0;
      mcnt   = 0;

      vt[0] = '{3'b000, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0};
      vt[1] = '{3'b001, 32'd3, 32'd3, 32'd0, 1'b1, 1'b0};
      vt[2] = '{3'b010, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0, 1'b0};
      vt[3] = '{3'b011, 32'h0000F000, 32'h0000000F, 32'h0000F00F, 1'b0, 1'b0};
      vt[4] = '{3'b101, 32'hFFFFFFE0, 32'd1, 32'd1, 1'b0, 1'b0};
      vt[5] = '{3'b101, 32'd1, 32'hFFFFFFE0, 32'd0, 1'b1, 1'b0};
      vt[6] = '{3'b000, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1, 1'b0};
      vt[7] = '{3'b100, 32'd9, 32'd9, 32'd0, 1'b1, 1'b1};

      // Reset state
      cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_result", result, 32'd0);
      chk("rst_zero", 32'(zero), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_op_count", 32'(op_count), 32'd0);

      // Basic ops then SLT / wrap / illegal
      for (int i = 0; i < 4; i++) apply_vec(i);
      idle(1'b1);
      chk("basic_op_count", 32'(op_count), 32'd4);
      for (int i = 4; i < 8; i++) apply_vec(i);
      idle(1'b1);
      chk("illegal_op_count", 32'(op_count), 32'd8);
      chk("drained_valid", 32'(out_valid), 32'd0);

      // Backpressure: A, B accepted, C held off
      cyc(1'b1, 1'b1, 3'd0, 32'd100, 32'd1, 1'b0);
      cyc(1'b1, 1'b1, 3'd0, 32'd200, 32'd2, 1'b0);
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_head_a", result, 32'd101);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 1'b1, 3'd0, 32'd300, 32'd3, 1'b0);
         chk("bp_head_stable", result, 32'd101);
         chk("bp_held_off", 32'(in_ready), 32'd0);
      end
      cyc(1'b1, 1'b1, 3'd0, 32'd300, 32'd3, 1'b1);
      chk("bp_pop_a_head_b", result, 32'd202);
      chk("bp_ready_back", 32'(in_ready), 32'd1);
      cyc(1'b1, 1'b1, 3'd0, 32'd300, 32'd3, 1'b1);
      chk("bp_head_c", result, 32'd303);
      idle(1'b1);
      chk("bp_empty", 32'(out_valid), 32'd0);
      chk("bp_op_count", 32'(op_count), 32'd11);

      // Reset mid-operation with two entries held
      cyc(1'b1, 1'b1, 3'd1, 32'd50, 32'd8, 1'b0);
      cyc(1'b1, 1'b1, 3'd3, 32'd6, 32'd1, 1'b0);
      chk("mr_full", 32'(in_ready), 32'd0);
      cyc(1'b0, 1'b0, 3'd0, '0, '0, 1'b0);
      chk("mr_out_valid", 32'(out_valid), 32'd0);
      chk("mr_in_ready", 32'(in_ready), 32'd1);
      chk("mr_op_count", 32'(op_count), 32'd0);
      chk("mr_result", result, 32'd0);
      idle(1'b1);
      chk("mr_no_ghost", 32'(out_valid), 32'd0);
      chk("mr_no_count", 32'(op_count), 32'd0);

      // Counter wrap: 17 pops
      for (int i = 0; i <= 17; i++) begin
         cyc(1'b1, (i < 17), 3'd2, 32'(i), 32'hFF, 1'b1);
         if (i == 15) chk("wrap_15", 32'(op_count), 32'd15);
         if (i == 16) chk("wrap_16", 32'(op_count), 32'd0);
         if (i == 17) chk("wrap_17", 32'(op_count), 32'd1);
      end

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = $urandom();
         b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom());
         if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 4));
         cyc(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)),
             3'($urandom_range(0, 7)), a, b, 1'($urandom_range(0, 2) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
